// File: rtl/host_monitor_pkg.sv
// Shared types and helpers for the host-communication monitor:
// character FIFO entry, channel-index width and address comparison.
package host_monitor_pkg;

   localparam int unsigned MAX_CH_W   = 8;
   localparam int unsigned MAX_ADDR_W = 128;

   typedef struct packed {
      logic [7:0]          data;
      logic [MAX_CH_W-1:0] ch;
   } char_entry_t;

   function automatic int unsigned ch_width(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   // Compare (waddr + base) against target, truncated to the low 'width' bits
   function automatic logic addr_match(input logic [MAX_ADDR_W-1:0] waddr,
                                       input logic [MAX_ADDR_W-1:0] base,
                                       input logic [MAX_ADDR_W-1:0] target,
                                       input int unsigned           width);
      logic [MAX_ADDR_W-1:0] mask;
      mask = (width >= MAX_ADDR_W) ? '1 : ((MAX_ADDR_W'(1) << width) - MAX_ADDR_W'(1));
      return (((waddr + base) ^ target) & mask) == '0;
   endfunction

endpackage

// File: rtl/host_char_fifo.sv
// Small synchronous FIFO for tagged characters; a push into a full FIFO is
// accepted when a pop happens in the same cycle.
module host_char_fifo #(
   parameter type         T     = logic [7:0],
   parameter int unsigned DEPTH = 16
) (
   input  logic clk_i,
   input  logic arst_i,
   input  logic push_i,
   input  T     data_i,
   input  logic pop_i,
   output logic valid_o,
   output logic push_ok_o,
   output T     data_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   T               r_mem [DEPTH];
   logic [PTR_W:0] r_wrPtr;
   logic [PTR_W:0] r_rdPtr;
   logic [PTR_W:0] w_count;
   logic           w_full;
   logic           w_pop;
   logic           w_push;

   // Pointers carry one extra bit so full (count == DEPTH) shows as the MSB
   assign w_count   = r_wrPtr - r_rdPtr;
   assign valid_o   = (w_count != '0);
   assign w_full    = w_count[PTR_W];
   assign w_pop     = pop_i & valid_o;
   assign w_push    = push_i & (~w_full | w_pop);
   assign push_ok_o = w_push;
   assign data_o    = valid_o ? r_mem[r_rdPtr[PTR_W-1:0]] : '0;

   always_ff @(posedge clk_i) begin
      if (w_push) begin
         r_mem[r_wrPtr[PTR_W-1:0]] <= data_i;
      end
   end

   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
      end else begin
         if (w_push) begin
            r_wrPtr <= r_wrPtr + (PTR_W+1)'(1);
         end
         if (w_pop) begin
            r_rdPtr <= r_rdPtr + (PTR_W+1)'(1);
         end
      end
   end

endmodule

// File: rtl/host_monitor.sv
// Snoops memory writes for per-hart putchar/tohost addresses, streams tagged
// characters and latches exit codes, and aggregates done/fail/timeout status.
module host_monitor
   import host_monitor_pkg::*;
#(
   parameter int unsigned       NUM_CH         = 2,
   parameter int unsigned       ADDR_W         = 64,
   parameter int unsigned       DATA_W         = 64,
   parameter logic [ADDR_W-1:0] MEM_BASE       = '0,
   parameter int unsigned       FIFO_DEPTH     = 16,
   parameter int unsigned       TIMEOUT_CYCLES = 100000,
   parameter int unsigned       CNT_W          = 32,
   localparam int unsigned      CH_W           = ch_width(NUM_CH),
   localparam int unsigned      STRB_W         = DATA_W / 8
) (
   input  logic                     clk_i,
   input  logic                     arst_i,
   input  logic                     enable_i,
   input  logic [NUM_CH*ADDR_W-1:0] putchar_addr_i,
   input  logic [NUM_CH*ADDR_W-1:0] tohost_addr_i,
   input  logic                     mem_we_i,
   input  logic [ADDR_W-1:0]        mem_waddr_i,
   input  logic [STRB_W-1:0]        mem_wstrb_i,
   input  logic [DATA_W-1:0]        mem_wdata_i,
   output logic                     char_valid_o,
   input  logic                     char_ready_i,
   output logic [7:0]               char_data_o,
   output logic [CH_W-1:0]          char_ch_o,
   output logic [NUM_CH-1:0]        exit_valid_o,
   output logic [NUM_CH*DATA_W-1:0] exit_code_o,
   output logic                     all_done_o,
   output logic                     fail_o,
   output logic                     timeout_o,
   output logic [CNT_W-1:0]         cycle_cnt_o,
   output logic [CNT_W-1:0]         drop_cnt_o
);

   logic [NUM_CH-1:0] w_putHit;
   logic [NUM_CH-1:0] w_toHit;
   logic              w_push;
   logic [CH_W-1:0]   w_putCh;
   logic [NUM_CH-1:0] w_capture;
   logic [DATA_W-1:0] w_maskedData;
   logic              w_pushOk;
   logic              w_allDone;
   logic              w_anyBad;
   logic              w_stop;
   char_entry_t       w_entry;
   char_entry_t       w_head;

   logic [NUM_CH-1:0] r_exitValid;
   logic [DATA_W-1:0] r_exitCode [NUM_CH];
   logic [CNT_W-1:0]  r_cycleCnt;
   logic [CNT_W-1:0]  r_dropCnt;
   logic              r_timeout;

   always_comb begin
      w_putHit = '0;
      w_toHit  = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         w_putHit[c] = enable_i & mem_we_i & mem_wstrb_i[0] &
                       addr_match(MAX_ADDR_W'(mem_waddr_i), MAX_ADDR_W'(MEM_BASE),
                                  MAX_ADDR_W'(putchar_addr_i[c*ADDR_W +: ADDR_W]), ADDR_W);
         w_toHit[c]  = enable_i & mem_we_i &
                       addr_match(MAX_ADDR_W'(mem_waddr_i), MAX_ADDR_W'(MEM_BASE),
                                  MAX_ADDR_W'(tohost_addr_i[c*ADDR_W +: ADDR_W]), ADDR_W);
      end
   end

   // Scan from the top so the lowest matching channel overrides the others
   always_comb begin
      w_push    = 1'b0;
      w_putCh   = '0;
      w_capture = '0;
      for (int c = NUM_CH - 1; c >= 0; c--) begin
         if (w_putHit[c]) begin
            w_push  = 1'b1;
            w_putCh = CH_W'(c);
         end
         if (w_toHit[c]) begin
            w_capture    = '0;
            w_capture[c] = ~r_exitValid[c];
         end
      end
   end

   always_comb begin
      w_maskedData = '0;
      for (int b = 0; b < STRB_W; b++) begin
         w_maskedData[b*8 +: 8] = mem_wstrb_i[b] ? mem_wdata_i[b*8 +: 8] : 8'h00;
      end
   end

   always_comb begin
      w_entry      = '0;
      w_entry.data = mem_wdata_i[7:0];
      w_entry.ch   = MAX_CH_W'(w_putCh);
   end

   host_char_fifo #(
      .T     (char_entry_t),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i     (clk_i),
      .arst_i    (arst_i),
      .push_i    (w_push),
      .data_i    (w_entry),
      .pop_i     (char_ready_i),
      .valid_o   (char_valid_o),
      .push_ok_o (w_pushOk),
      .data_o    (w_head)
   );

   assign char_data_o = w_head.data;
   assign char_ch_o   = CH_W'(w_head.ch);

   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         r_exitValid <= '0;
         for (int c = 0; c < NUM_CH; c++) begin
            r_exitCode[c] <= '0;
         end
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (w_capture[c]) begin
               r_exitValid[c] <= 1'b1;
               r_exitCode[c]  <= w_maskedData;
            end
         end
      end
   end

   always_comb begin
      w_anyBad    = 1'b0;
      exit_code_o = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         exit_code_o[c*DATA_W +: DATA_W] = r_exitCode[c];
         w_anyBad = w_anyBad | (r_exitValid[c] & (r_exitCode[c] != '0));
      end
   end

   assign w_allDone    = &r_exitValid;
   assign w_stop       = w_allDone | r_timeout;
   assign exit_valid_o = r_exitValid;
   assign all_done_o   = w_allDone;
   assign timeout_o    = r_timeout;
   assign fail_o       = r_timeout | w_anyBad;
   assign cycle_cnt_o  = r_cycleCnt;
   assign drop_cnt_o   = r_dropCnt;

   // Counters freeze once the run is over (all harts done or timed out)
   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         r_cycleCnt <= '0;
         r_dropCnt  <= '0;
         r_timeout  <= 1'b0;
      end else begin
         if (enable_i && !w_stop) begin
            if (r_cycleCnt != '1) begin
               r_cycleCnt <= r_cycleCnt + CNT_W'(1);
            end
            if ((TIMEOUT_CYCLES != 0) && (r_cycleCnt == CNT_W'(TIMEOUT_CYCLES - 1))) begin
               r_timeout <= 1'b1;
            end
         end
         if (w_push && !w_pushOk && !w_stop && (r_dropCnt != '1)) begin
            r_dropCnt <= r_dropCnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_host_monitor.sv
// Self-checking bench for host_monitor: directed scenarios plus a randomized
// phase, all compared against a queue-based reference model.
module tb_host_monitor;

   localparam int          NUM_CH  = 2;
   localparam int          ADDR_W  = 64;
   localparam int          DATA_W  = 64;
   localparam int          DEPTH   = 16;
   localparam int          TIMEOUT = 300;
   localparam int          CNT_W   = 32;
   localparam logic [63:0] BASE    = 64'h1000;
   localparam logic [63:0] PUT0    = 64'h8000_1000;
   localparam logic [63:0] PUT1    = 64'h8000_1008;
   localparam logic [63:0] TO0     = 64'h8000_2000;
   localparam logic [63:0] TO1     = 64'h8000_2008;

   logic                     clk_i = 1'b0;
   logic                     arst_i;
   logic                     enable_i;
   logic [NUM_CH*ADDR_W-1:0] putchar_addr_i;
   logic [NUM_CH*ADDR_W-1:0] tohost_addr_i;
   logic                     mem_we_i;
   logic [ADDR_W-1:0]        mem_waddr_i;
   logic [DATA_W/8-1:0]      mem_wstrb_i;
   logic [DATA_W-1:0]        mem_wdata_i;
   logic                     char_valid_o;
   logic                     char_ready_i;
   logic [7:0]               char_data_o;
   logic [0:0]               char_ch_o;
   logic [NUM_CH-1:0]        exit_valid_o;
   logic [NUM_CH*DATA_W-1:0] exit_code_o;
   logic                     all_done_o;
   logic                     fail_o;
   logic                     timeout_o;
   logic [CNT_W-1:0]         cycle_cnt_o;
   logic [CNT_W-1:0]         drop_cnt_o;

   host_monitor #(
      .NUM_CH         (NUM_CH),
      .ADDR_W         (ADDR_W),
      .DATA_W         (DATA_W),
      .MEM_BASE       (BASE),
      .FIFO_DEPTH     (DEPTH),
      .TIMEOUT_CYCLES (TIMEOUT),
      .CNT_W          (CNT_W)
   ) dut (
      .clk_i          (clk_i),
      .arst_i         (arst_i),
      .enable_i       (enable_i),
      .putchar_addr_i (putchar_addr_i),
      .tohost_addr_i  (tohost_addr_i),
      .mem_we_i       (mem_we_i),
      .mem_waddr_i    (mem_waddr_i),
      .mem_wstrb_i    (mem_wstrb_i),
      .mem_wdata_i    (mem_wdata_i),
      .char_valid_o   (char_valid_o),
      .char_ready_i   (char_ready_i),
      .char_data_o    (char_data_o),
      .char_ch_o      (char_ch_o),
      .exit_valid_o   (exit_valid_o),
      .exit_code_o    (exit_code_o),
      .all_done_o     (all_done_o),
      .fail_o         (fail_o),
      .timeout_o      (timeout_o),
      .cycle_cnt_o    (cycle_cnt_o),
      .drop_cnt_o     (drop_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   // Reference model: character stream as a queue of ch*256+byte
   int          modelQ[$];
   logic [1:0]  mValid;
   logic [63:0] mCode [2];
   int unsigned mCycle;
   int unsigned mDrop;
   logic        mTimeout;

   int passCount  = 0;
   int checkCount = 0;

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checkCount++;
      if (got === exp) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic modelReset();
      modelQ.delete();
      mValid   = 2'b00;
      mCode[0] = '0;
      mCode[1] = '0;
      mCycle   = 0;
      mDrop    = 0;
      mTimeout = 1'b0;
   endtask

   task automatic modelStep(input logic en, input logic we, input logic [63:0] addr,
                            input logic [7:0] strb, input logic [63:0] data, input logic ready);
      bit          stopped;
      bit          pushHit;
      int          pushCh;
      int          toCh;
      logic [63:0] eff;
      logic [63:0] code;
      stopped = (mValid == 2'b11) || mTimeout;
      pushHit = 0;
      pushCh  = 0;
      toCh    = -1;
      eff     = addr + BASE;
      if (en && we) begin
         if (strb[0]) begin
            if (eff == PUT0) begin
               pushHit = 1;
               pushCh  = 0;
            end else if (eff == PUT1) begin
               pushHit = 1;
               pushCh  = 1;
            end
         end
         if (eff == TO0) toCh = 0;
         else if (eff == TO1) toCh = 1;
      end
      if (ready && modelQ.size() > 0) void'(modelQ.pop_front());
      if (pushHit) begin
         if (modelQ.size() < DEPTH) modelQ.push_back(pushCh * 256 + int'(data[7:0]));
         else if (!stopped) mDrop++;
      end
      if (toCh >= 0 && !mValid[toCh]) begin
         code = '0;
         for (int b = 0; b < 8; b++) begin
            if (strb[b]) code[b*8 +: 8] = data[b*8 +: 8];
         end
         mCode[toCh]  = code;
         mValid[toCh] = 1'b1;
      end
      if (en && !stopped) begin
         if (mCycle == TIMEOUT - 1) mTimeout = 1'b1;
         mCycle++;
      end
   endtask

   task automatic compareAll();
      logic expFail;
      expFail = mTimeout || (mValid[0] && mCode[0] != 0) || (mValid[1] && mCode[1] != 0);
      checkOutput("char_valid", 64'(char_valid_o), 64'(modelQ.size() != 0));
      if (modelQ.size() != 0) begin
         checkOutput("char_data", 64'(char_data_o), 64'(modelQ[0] % 256));
         checkOutput("char_ch", 64'(char_ch_o), 64'(modelQ[0] / 256));
      end
      checkOutput("exit_valid", 64'(exit_valid_o), 64'(mValid));
      checkOutput("exit_code0", exit_code_o[63:0], mCode[0]);
      checkOutput("exit_code1", exit_code_o[127:64], mCode[1]);
      checkOutput("all_done", 64'(all_done_o), 64'(mValid == 2'b11));
      checkOutput("fail", 64'(fail_o), 64'(expFail));
      checkOutput("timeout", 64'(timeout_o), 64'(mTimeout));
      checkOutput("cycle_cnt", 64'(cycle_cnt_o), 64'(mCycle));
      checkOutput("drop_cnt", 64'(drop_cnt_o), 64'(mDrop));
   endtask

   // One clock of stimulus: drive at the falling edge, check after the next rise
   task automatic applyStimulus(input logic en, input logic we, input logic [63:0] addr,
                                input logic [7:0] strb, input logic [63:0] data, input logic ready);
      enable_i     = en;
      mem_we_i     = we;
      mem_waddr_i  = addr;
      mem_wstrb_i  = strb;
      mem_wdata_i  = data;
      char_ready_i = ready;
      modelStep(en, we, addr, strb, data, ready);
      @(posedge clk_i);
      @(negedge clk_i);
      compareAll();
   endtask

   task automatic idle(input logic ready);
      applyStimulus(1'b1, 1'b0, 64'h0, 8'h00, 64'h0, ready);
   endtask

   task automatic resetDut();
      enable_i     = 1'b1;
      mem_we_i     = 1'b0;
      mem_waddr_i  = '0;
      mem_wstrb_i  = '0;
      mem_wdata_i  = '0;
      char_ready_i = 1'b0;
      arst_i       = 1'b1;
      modelReset();
      @(negedge clk_i);
      compareAll();
      @(negedge clk_i);
      arst_i = 1'b0;
   endtask

   initial begin
      logic [7:0]  msg [4];
      logic [63:0] addr;
      int          sel;
      putchar_addr_i = {PUT1, PUT0};
      tohost_addr_i  = {TO1, TO0};
      resetDut();

      // Stream "Hi\n" on hart 0 then 'A' on hart 1 with the consumer ready
      msg[0] = 8'h48; msg[1] = 8'h69; msg[2] = 8'h0A; msg[3] = 8'h41;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 1'b1, ((i == 3) ? PUT1 : PUT0) - BASE, 8'h01, 64'(msg[i]), 1'b1);
         checkOutput("stream_byte", 64'(char_data_o), 64'(msg[i]));
         idle(1'b1);
      end

      // Fill past capacity with the consumer stalled, then drain in order
      resetDut();
      for (int i = 0; i < 20; i++) begin
         applyStimulus(1'b1, 1'b1, PUT0 - BASE, 8'h01, 64'(8'h30 + i), 1'b0);
      end
      checkOutput("drop_after_20", 64'(drop_cnt_o), 64'd4);
      checkOutput("first_held", 64'(char_data_o), 64'h30);
      for (int i = 0; i < 17; i++) idle(1'b1);
      checkOutput("drained", 64'(char_valid_o), 64'd0);

      // Exit codes: strobe masking, all done, nonzero fail, first write wins
      applyStimulus(1'b1, 1'b1, TO1 - BASE, 8'h0F, 64'hFFFF_FFFF_0000_0001, 1'b1);
      applyStimulus(1'b1, 1'b1, TO0 - BASE, 8'hFF, 64'h0, 1'b1);
      checkOutput("code1_masked", exit_code_o[127:64], 64'h1);
      checkOutput("done_fail", 64'({all_done_o, fail_o}), 64'b11);
      applyStimulus(1'b1, 1'b1, TO0 - BASE, 8'hFF, 64'hDEAD, 1'b1);
      checkOutput("code0_first_wins", exit_code_o[63:0], 64'h0);
      for (int i = 0; i < 3; i++) idle(1'b1);

      // Timeout with no tohost writes; cycle counter freezes
      resetDut();
      for (int i = 0; i < TIMEOUT + 10; i++) idle(1'b1);
      checkOutput("timeout_hold", 64'(cycle_cnt_o), 64'(TIMEOUT));
      checkOutput("timeout_fail", 64'({timeout_o, fail_o}), 64'b11);

      // Randomized traffic
      resetDut();
      for (int i = 0; i < 500; i++) begin
         sel = $urandom_range(0, 31);
         if (sel < 12) addr = PUT0 - BASE;
         else if (sel < 22) addr = PUT1 - BASE;
         else if (sel == 22) addr = TO0 - BASE;
         else if (sel == 23) addr = TO1 - BASE;
         else addr = {$urandom, $urandom};
         applyStimulus(($urandom_range(0, 9) != 0), 1'($urandom), addr, 8'($urandom),
                       {$urandom, $urandom}, 1'($urandom));
      end

      // Asynchronous reset with characters queued
      resetDut();
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 1'b1, PUT1 - BASE, 8'h01, 64'(8'h61 + i), 1'b0);
      end
      #2 arst_i = 1'b1;
      #1;
      checkOutput("rst_valid", 64'(char_valid_o), 64'd0);
      checkOutput("rst_cycle", 64'(cycle_cnt_o), 64'd0);
      checkOutput("rst_drop", 64'(drop_cnt_o), 64'd0);
      modelReset();
      @(negedge clk_i);
      arst_i = 1'b0;
      compareAll();
      applyStimulus(1'b1, 1'b1, PUT0 - BASE, 8'h01, 64'h5A, 1'b0);
      checkOutput("post_rst_first", 64'(char_data_o), 64'h5A);
      idle(1'b1);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/host_monitor.md
Name: host_monitor

Overview:
- Synthesizable, parametrised host-communication monitor for multi-hart simulation and emulation.
- Snoops the write side of the memory port (mem_we/waddr/wdata/wstrb), as exposed by the AXI RAM.
- Per channel (hart), it captures putchar bytes into a tagged character stream and latches the first tohost write as that channel's exit code.
- Aggregates done/fail/timeout status for the top-level bench or an FPGA host bridge.

Parameters:
- NUM_CH, 2, number of channels (harts); each has its own putchar/tohost address.
- ADDR_W, 64, snooped address width.
- DATA_W, 64, snooped data width; power of two, >= 8.
- MEM_BASE, 0, added to mem_waddr_i before every address compare.
- FIFO_DEPTH, 16, character FIFO entries; power of two, >= 2.
- TIMEOUT_CYCLES, 100000, cycles before timeout; 0 disables timeout.
- CNT_W, 32, width of the cycle counter and the drop counter.

Ports:
- clk_i  in  1  clock.
- arst_i  in  1  asynchronous active-high reset.
- enable_i  in  1  snoop and count enable; when low, nothing is captured and counters hold.
- putchar_addr_i  in  NUM_CH*ADDR_W  per-channel putchar byte address; channel c occupies slice c.
- tohost_addr_i  in  NUM_CH*ADDR_W  per-channel tohost address.
- mem_we_i  in  1  memory write enable.
- mem_waddr_i  in  ADDR_W  memory write address, relative to MEM_BASE.
- mem_wstrb_i  in  DATA_W/8  byte strobes.
- mem_wdata_i  in  DATA_W  write data.
- char_valid_o  out  1  character available.
- char_ready_i  in  1  consumer accepts the character.
- char_data_o  out  8  character byte.
- char_ch_o  out  $clog2(NUM_CH) (min 1)  source channel of the character.
- exit_valid_o  out  NUM_CH  per-channel exit code captured (sticky).
- exit_code_o  out  NUM_CH*DATA_W  per-channel exit code.
- all_done_o  out  1  all exit_valid_o bits set.
- fail_o  out  1  any captured exit code nonzero, or timeout.
- timeout_o  out  1  timeout reached before all_done_o (sticky).
- cycle_cnt_o  out  CNT_W  enabled cycles since reset, saturating.
- drop_cnt_o  out  CNT_W  characters dropped on FIFO full, saturating.

Behaviour:
- Reset (async assert, synchronous release): all outputs 0; FIFO empty; counters 0; exit codes 0.
- Hit definition, evaluated each rising edge: enable_i & mem_we_i & (mem_waddr_i + MEM_BASE == addr), with the sum truncated to ADDR_W.
- Putchar hit on channel c also requires mem_wstrb_i[0].
  - Byte pushed is mem_wdata_i[7:0], tag c.
  - The push is visible on char_valid_o the next cycle (1-cycle latency).
- Tohost hit on channel c with exit_valid_o[c]==0:
  - exit_code_o[c] latches mem_wdata_i bytes where the strobe is set; unstrobed bytes are 0.
  - exit_valid_o[c] sets the next cycle.
  - Later tohost writes to c are ignored: first write wins.
- Address matches two channels: lowest index wins.
- Address matches both putchar and tohost: both actions happen.
- Character FIFO:
  - Push when full and no pop in the same cycle: byte discarded, drop_cnt_o increments.
  - Push when full with a simultaneous pop (char_valid_o & char_ready_i): push accepted.
  - Pop when empty: no effect.
  - char_data_o/char_ch_o stable while char_valid_o is high and char_ready_i is low.
  - Pointers wrap modulo FIFO_DEPTH.
- all_done_o = &exit_valid_o (combinational from registers).
- fail_o = timeout_o | (OR over c of exit_valid_o[c] & (exit_code_o[c] != 0)).
- cycle_cnt_o increments each enabled cycle and saturates at all-ones.
- Timeout:
  - timeout_o sets when TIMEOUT_CYCLES != 0, cycle_cnt_o == TIMEOUT_CYCLES-1, enabled, and !all_done_o.
  - Once set it is sticky; it never sets after all_done_o.
- Counters stop incrementing after all_done_o or timeout_o.
- Reset mid-operation clears the FIFO; in-flight characters are lost.

Decomposition:
- host_monitor_pkg holds:
  - char_entry_t {logic [7:0] data; logic [CH_W-1:0] ch;}.
  - Function ch_width(n) returning max(1, $clog2(n)).
  - Address-compare helper.
- One sub-module: host_char_fifo (parametrised type/depth, same-cycle push/pop at full, async active-high reset).

Test Plan:
- Write 'H','i','\n' to putchar[0], then 'A' to putchar[1], char_ready_i=1 -> stream (0x48,0),(0x69,0),(0x0A,0),(0x41,1), each 1 cycle after its write.
- char_ready_i=0, 20 putchar writes with FIFO_DEPTH=16 -> 16 entries held, drop_cnt_o=4; first popped byte is the first written.
- tohost[1] write 0x1 with wstrb=0x0F, then tohost[0] write 0x0 with wstrb=0xFF -> exit_code_o[1]=0x1, all_done_o=1, fail_o=1.
- Second tohost[0] write 0xDEAD after capture -> exit_code_o[0] stays 0.
- TIMEOUT_CYCLES=50, no tohost writes -> timeout_o and fail_o rise when cycle_cnt_o reaches 50, and cycle_cnt_o holds at 50.
- Assert arst_i mid-stream with 5 entries queued -> char_valid_o=0, counters 0 immediately; a post-reset putchar produces the first entry.
